// File: rtl/their_seq_ack_gen.sv
// their_seq_ack_gen: validates peer segment sequence numbers against per-flow rcv_nxt,
// sizes the accepted payload and requests coalesced or duplicate ACKs.
module their_seq_ack_gen #(
    parameter int NUM_FLOWS   = 8,
    parameter int FLOW_ID_W   = 3,
    parameter int ACK_EVERY_N = 2,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_val,
    input  logic [FLOW_ID_W-1:0] init_flow,
    input  logic [31:0]          init_seq,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [FLOW_ID_W-1:0] in_flow,
    input  logic [31:0]          in_seq,
    input  logic [15:0]          in_len,
    input  logic [15:0]          in_free,
    input  logic                 flush_val,
    input  logic [FLOW_ID_W-1:0] flush_flow,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [FLOW_ID_W-1:0] out_flow,
    output logic                 out_accept,
    output logic [15:0]          out_trim,
    output logic [15:0]          out_acc_len,
    output logic                 out_send_ack,
    output logic                 out_dup,
    output logic [31:0]          out_ack_num
);
    localparam logic [CNT_W:0] ACK_N = (CNT_W+1)'(ACK_EVERY_N);
    logic [31:0]          rcv_nxt_q [NUM_FLOWS];
    logic [31:0]          rcv_nxt_d [NUM_FLOWS];
    logic [CNT_W-1:0]     cnt_q [NUM_FLOWS];
    logic [CNT_W-1:0]     cnt_d [NUM_FLOWS];
    logic                 out_val_q, out_val_d;
    logic [FLOW_ID_W-1:0] out_flow_q, out_flow_d;
    logic                 out_accept_q, out_accept_d;
    logic [15:0]          out_trim_q, out_trim_d;
    logic [15:0]          out_acc_len_q, out_acc_len_d;
    logic                 out_send_ack_q, out_send_ack_d;
    logic                 out_dup_q, out_dup_d;
    logic [31:0]          out_ack_num_q, out_ack_num_d;
    logic                 slot_free, do_flush, do_seg;
    logic [31:0]          cur_rcv, fl_rcv, d, e, new_rcv;
    logic [CNT_W-1:0]     cur_cnt, fl_cnt, cnt_sat, seg_cnt;
    logic [CNT_W:0]       cnt_inc;
    logic [15:0]          trim, acc_len;
    logic                 is_old, is_future, drop, in_order, ack_now;
    assign slot_free = ~out_val_q | out_rdy;
    assign in_rdy    = rst_n & ~init_val & ~flush_val & slot_free;
    assign do_flush  = ~init_val & flush_val & slot_free;
    assign do_seg    = in_val & in_rdy & (in_len != 16'd0);
    assign cur_rcv   = rcv_nxt_q[in_flow];
    assign cur_cnt   = cnt_q[in_flow];
    assign fl_rcv    = rcv_nxt_q[flush_flow];
    assign fl_cnt    = cnt_q[flush_flow];
    // d <= 0 and e > 0 bound both trim and acc_len below in_len, so 16 bits suffice
    assign d         = in_seq - cur_rcv;
    assign e         = d + {16'h0, in_len};
    assign is_old    = e[31] | (e == 32'd0);
    assign is_future = ~d[31] & (d != 32'd0);
    assign trim      = 16'(32'd0 - d);
    assign acc_len   = e[15:0];
    assign drop      = acc_len > in_free;
    assign in_order  = ~is_old & ~is_future & ~drop;
    assign cnt_inc   = {1'b0, cur_cnt} + 1'b1;
    assign cnt_sat   = &cur_cnt ? cur_cnt : cnt_inc[CNT_W-1:0];
    assign ack_now   = (cnt_inc >= ACK_N) | (trim != 16'd0);
    assign new_rcv   = in_order ? cur_rcv + {16'h0, acc_len} : cur_rcv;
    assign seg_cnt   = is_old ? '0 : in_order ? (ack_now ? '0 : cnt_sat) : cur_cnt;
    always_comb begin
        rcv_nxt_d      = rcv_nxt_q;
        cnt_d          = cnt_q;
        out_val_d      = out_val_q & ~out_rdy;
        out_flow_d     = out_flow_q;
        out_accept_d   = out_accept_q;
        out_trim_d     = out_trim_q;
        out_acc_len_d  = out_acc_len_q;
        out_send_ack_d = out_send_ack_q;
        out_dup_d      = out_dup_q;
        out_ack_num_d  = out_ack_num_q;
        if (init_val) begin
            rcv_nxt_d[init_flow] = init_seq;
            cnt_d[init_flow]     = '0;
        end else if (do_flush) begin
            cnt_d[flush_flow] = '0;
            if (fl_cnt != '0) begin
                out_val_d      = 1'b1;
                out_flow_d     = flush_flow;
                out_accept_d   = 1'b0;
                out_trim_d     = 16'd0;
                out_acc_len_d  = 16'd0;
                out_send_ack_d = 1'b1;
                out_dup_d      = 1'b0;
                out_ack_num_d  = fl_rcv;
            end
        end else if (do_seg) begin
            rcv_nxt_d[in_flow] = new_rcv;
            cnt_d[in_flow]     = seg_cnt;
            out_val_d          = 1'b1;
            out_flow_d         = in_flow;
            out_accept_d       = in_order;
            out_trim_d         = in_order ? trim : 16'd0;
            out_acc_len_d      = in_order ? acc_len : 16'd0;
            out_send_ack_d     = ~in_order | ack_now;
            out_dup_d          = ~in_order;
            out_ack_num_d      = new_rcv;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                rcv_nxt_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
            out_val_q      <= 1'b0;
            out_flow_q     <= '0;
            out_accept_q   <= 1'b0;
            out_trim_q     <= '0;
            out_acc_len_q  <= '0;
            out_send_ack_q <= 1'b0;
            out_dup_q      <= 1'b0;
            out_ack_num_q  <= '0;
        end else begin
            rcv_nxt_q      <= rcv_nxt_d;
            cnt_q          <= cnt_d;
            out_val_q      <= out_val_d;
            out_flow_q     <= out_flow_d;
            out_accept_q   <= out_accept_d;
            out_trim_q     <= out_trim_d;
            out_acc_len_q  <= out_acc_len_d;
            out_send_ack_q <= out_send_ack_d;
            out_dup_q      <= out_dup_d;
            out_ack_num_q  <= out_ack_num_d;
        end
    end
    assign out_val      = out_val_q;
    assign out_flow     = out_flow_q;
    assign out_accept   = out_accept_q;
    assign out_trim     = out_trim_q;
    assign out_acc_len  = out_acc_len_q;
    assign out_send_ack = out_send_ack_q;
    assign out_dup      = out_dup_q;
    assign out_ack_num  = out_ack_num_q;
endmodule

// File: tb/tb_their_seq_ack_gen.sv
// tb_their_seq_ack_gen: directed scenarios with hand-computed expectations for their_seq_ack_gen.
module tb_their_seq_ack_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_val, in_val, flush_val, out_rdy;
    logic [2:0]  init_flow, in_flow, flush_flow;
    logic [31:0] init_seq, in_seq;
    logic [15:0] in_len, in_free;
    logic        in_rdy, out_val, out_accept, out_send_ack, out_dup;
    logic [2:0]  out_flow;
    logic [15:0] out_trim, out_acc_len;
    logic [31:0] out_ack_num;
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    their_seq_ack_gen dut (
        .clk(clk), .rst_n(rst_n),
        .init_val(init_val), .init_flow(init_flow), .init_seq(init_seq),
        .in_val(in_val), .in_rdy(in_rdy), .in_flow(in_flow), .in_seq(in_seq),
        .in_len(in_len), .in_free(in_free),
        .flush_val(flush_val), .flush_flow(flush_flow),
        .out_val(out_val), .out_rdy(out_rdy), .out_flow(out_flow),
        .out_accept(out_accept), .out_trim(out_trim), .out_acc_len(out_acc_len),
        .out_send_ack(out_send_ack), .out_dup(out_dup), .out_ack_num(out_ack_num)
    );
    task automatic do_init(input logic [2:0] f, input logic [31:0] s);
        @(negedge clk);
        init_val = 1'b1; init_flow = f; init_seq = s;
        @(posedge clk); #1;
        init_val = 1'b0;
    endtask
    task automatic do_seg(input logic [2:0] f, input logic [31:0] s, input logic [15:0] l, input logic [15:0] fr);
        @(negedge clk);
        in_val = 1'b1; in_flow = f; in_seq = s; in_len = l; in_free = fr;
        @(posedge clk); #1;
        in_val = 1'b0;
    endtask
    task automatic test_reset;
        #2;
        n_vec++; if (out_val !== 1'b0) begin n_err++; $display("FAIL rst_out_val got %b want 0", out_val); end
        n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rst_in_rdy got %b want 0", in_rdy); end
        n_vec++; if (out_ack_num !== 32'd0) begin n_err++; $display("FAIL rst_ack_num got %0h want 0", out_ack_num); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL post_rst_in_rdy got %b want 1", in_rdy); end
    endtask
    task automatic test_in_order;
        do_init(3'd2, 32'd1000);
        n_vec++; if (out_val !== 1'b0) begin n_err++; $display("FAIL init_no_out got %b want 0", out_val); end
        do_seg(3'd2, 32'd1000, 16'd100, 16'd1000);
        n_vec++; if (out_val !== 1'b1 || out_accept !== 1'b1 || out_send_ack !== 1'b0 || out_ack_num !== 32'd1100 || out_acc_len !== 16'd100 || out_flow !== 3'd2)
            begin n_err++; $display("FAIL seg1 got val=%b acc=%b ack=%b num=%0d len=%0d flow=%0d want 1 1 0 1100 100 2", out_val, out_accept, out_send_ack, out_ack_num, out_acc_len, out_flow); end
        do_seg(3'd2, 32'd1100, 16'd100, 16'd1000);
        n_vec++; if (out_send_ack !== 1'b1 || out_dup !== 1'b0 || out_ack_num !== 32'd1200 || out_accept !== 1'b1)
            begin n_err++; $display("FAIL seg2 got ack=%b dup=%b num=%0d acc=%b want 1 0 1200 1", out_send_ack, out_dup, out_ack_num, out_accept); end
    endtask
    task automatic test_future;
        do_seg(3'd2, 32'd1300, 16'd50, 16'd1000);
        n_vec++; if (out_accept !== 1'b0 || out_dup !== 1'b1 || out_send_ack !== 1'b1 || out_ack_num !== 32'd1200)
            begin n_err++; $display("FAIL future got acc=%b dup=%b ack=%b num=%0d want 0 1 1 1200", out_accept, out_dup, out_send_ack, out_ack_num); end
    endtask
    task automatic test_overlap;
        do_seg(3'd2, 32'd1150, 16'd100, 16'd1000);
        n_vec++; if (out_accept !== 1'b1 || out_trim !== 16'd50 || out_acc_len !== 16'd50 || out_ack_num !== 32'd1250 || out_send_ack !== 1'b1 || out_dup !== 1'b0)
            begin n_err++; $display("FAIL overlap got acc=%b trim=%0d len=%0d num=%0d ack=%b dup=%b want 1 50 50 1250 1 0", out_accept, out_trim, out_acc_len, out_ack_num, out_send_ack, out_dup); end
    endtask
    task automatic test_old_and_pure;
        do_seg(3'd2, 32'd1100, 16'd100, 16'd1000);
        n_vec++; if (out_accept !== 1'b0 || out_dup !== 1'b1 || out_send_ack !== 1'b1 || out_ack_num !== 32'd1250)
            begin n_err++; $display("FAIL old got acc=%b dup=%b ack=%b num=%0d want 0 1 1 1250", out_accept, out_dup, out_send_ack, out_ack_num); end
        do_seg(3'd2, 32'd1250, 16'd0, 16'd1000);
        n_vec++; if (out_val !== 1'b0) begin n_err++; $display("FAIL pure_ack_out got %b want 0", out_val); end
    endtask
    task automatic test_wrap_and_drop;
        do_init(3'd5, 32'hFFFF_FFF0);
        do_seg(3'd5, 32'hFFFF_FFF0, 16'd32, 16'd1000);
        n_vec++; if (out_accept !== 1'b1 || out_ack_num !== 32'h0000_0010 || out_send_ack !== 1'b0 || out_acc_len !== 16'd32)
            begin n_err++; $display("FAIL wrap got acc=%b num=%0h ack=%b len=%0d want 1 10 0 32", out_accept, out_ack_num, out_send_ack, out_acc_len); end
        do_seg(3'd5, 32'h10, 16'd100, 16'd40);
        n_vec++; if (out_accept !== 1'b0 || out_dup !== 1'b1 || out_send_ack !== 1'b1 || out_ack_num !== 32'h10)
            begin n_err++; $display("FAIL drop got acc=%b dup=%b ack=%b num=%0h want 0 1 1 10", out_accept, out_dup, out_send_ack, out_ack_num); end
        do_seg(3'd5, 32'h10, 16'd20, 16'd40);
        n_vec++; if (out_accept !== 1'b1 || out_send_ack !== 1'b1 || out_dup !== 1'b0 || out_ack_num !== 32'h24)
            begin n_err++; $display("FAIL after_drop got acc=%b ack=%b dup=%b num=%0h want 1 1 0 24", out_accept, out_send_ack, out_dup, out_ack_num); end
    endtask
    task automatic test_flush_stall;
        do_init(3'd1, 32'd500);
        do_seg(3'd1, 32'd500, 16'd10, 16'd1000);
        n_vec++; if (out_send_ack !== 1'b0 || out_ack_num !== 32'd510)
            begin n_err++; $display("FAIL pre_flush got ack=%b num=%0d want 0 510", out_send_ack, out_ack_num); end
        @(negedge clk);
        flush_val = 1'b1; flush_flow = 3'd1;
        #1;
        n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL flush_in_rdy got %b want 0", in_rdy); end
        @(posedge clk); #1;
        flush_val = 1'b0;
        n_vec++; if (out_val !== 1'b1 || out_send_ack !== 1'b1 || out_dup !== 1'b0 || out_accept !== 1'b0 || out_ack_num !== 32'd510 || out_flow !== 3'd1)
            begin n_err++; $display("FAIL flush got val=%b ack=%b dup=%b acc=%b num=%0d flow=%0d want 1 1 0 0 510 1", out_val, out_send_ack, out_dup, out_accept, out_ack_num, out_flow); end
        @(negedge clk);
        out_rdy = 1'b0;
        in_val = 1'b1; in_flow = 3'd1; in_seq = 32'd510; in_len = 16'd10; in_free = 16'd1000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++; if (in_rdy !== 1'b0 || out_val !== 1'b1 || out_ack_num !== 32'd510 || out_send_ack !== 1'b1)
                begin n_err++; $display("FAIL stall%0d got rdy=%b val=%b num=%0d ack=%b want 0 1 510 1", i, in_rdy, out_val, out_ack_num, out_send_ack); end
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_val !== 1'b0 || in_rdy !== 1'b0)
            begin n_err++; $display("FAIL mid_rst got val=%b rdy=%b want 0 0", out_val, in_rdy); end
        in_val = 1'b0; out_rdy = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        flush_val = 1'b1; flush_flow = 3'd2;
        @(posedge clk); #1;
        flush_val = 1'b0;
        n_vec++; if (out_val !== 1'b0) begin n_err++; $display("FAIL flush_after_rst got %b want 0", out_val); end
    endtask
    initial begin
        rst_n = 1'b0; init_val = 1'b0; in_val = 1'b0; flush_val = 1'b0; out_rdy = 1'b1;
        init_flow = '0; in_flow = '0; flush_flow = '0; init_seq = '0; in_seq = '0;
        in_len = '0; in_free = '0;
        test_reset;
        test_in_order;
        test_future;
        test_overlap;
        test_old_and_pure;
        test_wrap_and_drop;
        test_flush_stall;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
